// File: rtl/ber_reg_pkg.sv
// Shared definitions for the BER register bridge: command-word fields, opcodes, FSM encoding.
package ber_reg_pkg;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 24;
  localparam int STB_BIT = 23;
  localparam int PAY_MSB = 22;

  localparam logic [7:0] OP_RESET      = 8'h01;
  localparam logic [7:0] OP_EN_TX      = 8'h02;
  localparam logic [7:0] OP_EN_RX      = 8'h03;
  localparam logic [7:0] OP_PHASE      = 8'h04;
  localparam logic [7:0] OP_SNAPSHOT   = 8'h05;
  localparam logic [7:0] OP_RD_ERR_LO  = 8'h06;
  localparam logic [7:0] OP_RD_ERR_HI  = 8'h07;
  localparam logic [7:0] OP_RD_BITS_LO = 8'h08;
  localparam logic [7:0] OP_RD_BITS_HI = 8'h09;
  localparam logic [7:0] OP_STATUS     = 8'h0A;
  localparam logic [7:0] OP_TSTAMP     = 8'h0B;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_RST_PULSE,
    S_WAIT_LOW
  } state_t;

endpackage

// File: rtl/ber_snapshot_reg.sv
// Coherent snapshot of the BER counters with a half-word read mux.
// With BER_REG_TIMESTAMP_EN defined, a cycle timestamp is captured alongside.
module ber_snapshot_reg
  import ber_reg_pkg::*;
#(
  parameter int NB_GPIO  = 32,
  parameter int NB_COUNT = 64
) (
  input  logic                clock,
  input  logic                i_reset,
  input  logic                i_capture,
  input  logic [NB_COUNT-1:0] i_bits_count,
  input  logic [NB_COUNT-1:0] i_error_count,
`ifdef BER_REG_TIMESTAMP_EN
  input  logic [31:0]         i_tstamp,
`endif
  input  logic [7:0]          i_rd_op,
  output logic [NB_GPIO-1:0]  o_rd_data
);

  logic [NB_COUNT-1:0] r_bits;
  logic [NB_COUNT-1:0] r_errs;
`ifdef BER_REG_TIMESTAMP_EN
  logic [31:0]         r_tstamp;
`endif

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      r_bits   <= '0;
      r_errs   <= '0;
`ifdef BER_REG_TIMESTAMP_EN
      r_tstamp <= '0;
`endif
    end else if (i_capture) begin
      r_bits   <= i_bits_count;
      r_errs   <= i_error_count;
`ifdef BER_REG_TIMESTAMP_EN
      r_tstamp <= i_tstamp;
`endif
    end
  end

  always_comb begin
    o_rd_data = '0;
    case (i_rd_op)
      OP_RD_ERR_LO:  o_rd_data = r_errs[NB_GPIO-1:0];
      OP_RD_ERR_HI:  o_rd_data = r_errs[NB_COUNT-1:NB_GPIO];
      OP_RD_BITS_LO: o_rd_data = r_bits[NB_GPIO-1:0];
      OP_RD_BITS_HI: o_rd_data = r_bits[NB_COUNT-1:NB_GPIO];
`ifdef BER_REG_TIMESTAMP_EN
      OP_TSTAMP:     o_rd_data = NB_GPIO'(r_tstamp);
`endif
      default:       o_rd_data = '0;
    endcase
  end

endmodule

// File: rtl/ber_reg_bridge.sv
// GPO/GPI command bridge to the BER checker: decodes strobed commands and drives BER controls.
// Optional BER_REG_TIMESTAMP_EN adds a free-running cycle timestamp captured on SNAPSHOT.
module ber_reg_bridge
  import ber_reg_pkg::*;
#(
  parameter int NB_GPIO      = 32,
  parameter int NB_COUNT     = 64,
  parameter int NB_PHASE     = 2,
  parameter int RESET_CYCLES = 4
) (
  input  logic                clock,
  input  logic                i_reset,
  input  logic [NB_GPIO-1:0]  i_gpo_data,
  input  logic [NB_COUNT-1:0] i_bits_count,
  input  logic [NB_COUNT-1:0] i_error_count,
  input  logic                i_led,
  output logic [NB_GPIO-1:0]  o_gpi_data,
  output logic                o_ack,
  output logic                o_reset_sinc,
  output logic                o_enable_tx,
  output logic                o_enable_rx,
  output logic [NB_PHASE-1:0] o_phase_sel
);

  localparam int CNT_W = $clog2(RESET_CYCLES + 1);

  state_t             r_state;
  state_t             w_next;
  logic               r_strobe_d;
  logic [7:0]         r_opcode;
  logic [PAY_MSB:0]   r_payload;
  logic [CNT_W-1:0]   r_rst_cnt;
  logic               r_invalid;
  logic               w_strobe;
  logic               w_rise;
  logic               w_exec;
  logic               w_valid;
  logic               w_is_read;
  logic [NB_GPIO-1:0] w_snap_rd;
  logic               w_unused_payload;

  assign w_strobe         = i_gpo_data[STB_BIT];
  assign w_rise           = w_strobe & ~r_strobe_d;
  assign w_exec           = (r_state == S_EXEC);
  assign w_unused_payload = ^r_payload[PAY_MSB:NB_PHASE];

`ifdef BER_REG_TIMESTAMP_EN
  logic [31:0] r_tstamp;
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) r_tstamp <= '0;
    else          r_tstamp <= r_tstamp + 32'd1;
  end
`endif

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state    <= S_IDLE;
      r_strobe_d <= 1'b0;
      r_opcode   <= '0;
      r_payload  <= '0;
      r_rst_cnt  <= '0;
    end else begin
      r_state    <= w_next;
      r_strobe_d <= w_strobe;
      if (r_state == S_IDLE && w_rise) begin
        r_opcode  <= i_gpo_data[OPC_MSB:OPC_LSB];
        r_payload <= i_gpo_data[PAY_MSB:0];
      end
      if (r_state == S_RST_PULSE) r_rst_cnt <= r_rst_cnt + 1'b1;
      else                        r_rst_cnt <= '0;
    end
  end

  // ack and the reset pulse are pure state decodes so an async reset clears them at once
  always_comb begin
    w_next       = r_state;
    o_ack        = 1'b0;
    o_reset_sinc = 1'b0;
    case (r_state)
      S_IDLE:      if (w_rise) w_next = S_EXEC;
      S_EXEC:      w_next = (r_opcode == OP_RESET) ? S_RST_PULSE : S_WAIT_LOW;
      S_RST_PULSE: begin
        o_reset_sinc = 1'b1;
        if (r_rst_cnt == CNT_W'(RESET_CYCLES - 1)) w_next = S_WAIT_LOW;
      end
      S_WAIT_LOW:  begin
        o_ack = 1'b1;
        if (!w_strobe) w_next = S_IDLE;
      end
      default:     w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_valid   = 1'b1;
    w_is_read = 1'b0;
    case (r_opcode)
      OP_RESET, OP_EN_TX, OP_EN_RX, OP_PHASE, OP_SNAPSHOT, OP_STATUS: w_valid = 1'b1;
      OP_RD_ERR_LO, OP_RD_ERR_HI, OP_RD_BITS_LO, OP_RD_BITS_HI:      w_is_read = 1'b1;
`ifdef BER_REG_TIMESTAMP_EN
      OP_TSTAMP:                                                      w_is_read = 1'b1;
`endif
      default:                                                        w_valid = 1'b0;
    endcase
  end

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      o_enable_tx <= 1'b0;
      o_enable_rx <= 1'b0;
      o_phase_sel <= '0;
      o_gpi_data  <= '0;
      r_invalid   <= 1'b0;
    end else if (w_exec) begin
      r_invalid <= ~w_valid;
      case (r_opcode)
        OP_EN_TX:  o_enable_tx <= r_payload[0];
        OP_EN_RX:  o_enable_rx <= r_payload[0];
        OP_PHASE:  o_phase_sel <= r_payload[NB_PHASE-1:0];
        OP_STATUS: o_gpi_data  <= NB_GPIO'({r_invalid, i_led, o_enable_rx});
        default:   if (w_is_read) o_gpi_data <= w_snap_rd;
      endcase
    end
  end

  ber_snapshot_reg #(
    .NB_GPIO  (NB_GPIO),
    .NB_COUNT (NB_COUNT)
  ) u_snap (
    .clock         (clock),
    .i_reset       (i_reset),
    .i_capture     (w_exec && (r_opcode == OP_SNAPSHOT)),
    .i_bits_count  (i_bits_count),
    .i_error_count (i_error_count),
`ifdef BER_REG_TIMESTAMP_EN
    .i_tstamp      (r_tstamp),
`endif
    .i_rd_op       (r_opcode),
    .o_rd_data     (w_snap_rd)
  );

endmodule

// File: tb/tb_ber_reg_bridge.sv
// Scoreboard bench for ber_reg_bridge: expected register state is queued per command and checked on ack.
module tb_ber_reg_bridge;

  localparam int RESET_CYCLES = 4;

  logic        clock = 1'b0;
  logic        rst_n;
  logic [31:0] gpo;
  logic [63:0] bits;
  logic [63:0] errs;
  logic        led;
  logic [31:0] gpi;
  logic        ack;
  logic        rst_sinc;
  logic        en_tx;
  logic        en_rx;
  logic [1:0]  phase;

  always #5 clock = ~clock;

  ber_reg_bridge #(
    .NB_GPIO      (32),
    .NB_COUNT     (64),
    .NB_PHASE     (2),
    .RESET_CYCLES (RESET_CYCLES)
  ) dut (
    .clock         (clock),
    .i_reset       (rst_n),
    .i_gpo_data    (gpo),
    .i_bits_count  (bits),
    .i_error_count (errs),
    .i_led         (led),
    .o_gpi_data    (gpi),
    .o_ack         (ack),
    .o_reset_sinc  (rst_sinc),
    .o_enable_tx   (en_tx),
    .o_enable_rx   (en_rx),
    .o_phase_sel   (phase)
  );

  typedef struct packed {
    logic [31:0] gpi;
    logic        tx;
    logic        rx;
    logic [1:0]  phase;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] m_gpi;
  logic        m_tx, m_rx, m_inv;
  logic [1:0]  m_phase;
  logic [63:0] m_bits, m_errs;
  int          total = 0;
  int          bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_gpi = '0; m_tx = 1'b0; m_rx = 1'b0; m_inv = 1'b0;
    m_phase = '0; m_bits = '0; m_errs = '0;
    sb_q.delete();
  endtask

  task automatic model_cmd(input logic [7:0] op, input logic [22:0] pl);
    exp_t e;
    logic valid;
    valid = 1'b1;
    case (op)
      8'h01: ;
      8'h02: m_tx = pl[0];
      8'h03: m_rx = pl[0];
      8'h04: m_phase = pl[1:0];
      8'h05: begin m_bits = bits; m_errs = errs; end
      8'h06: m_gpi = m_errs[31:0];
      8'h07: m_gpi = m_errs[63:32];
      8'h08: m_gpi = m_bits[31:0];
      8'h09: m_gpi = m_bits[63:32];
      8'h0A: m_gpi = {29'b0, m_inv, led, m_rx};
      default: valid = 1'b0;
    endcase
    m_inv   = ~valid;
    e.gpi   = m_gpi;
    e.tx    = m_tx;
    e.rx    = m_rx;
    e.phase = m_phase;
    sb_q.push_back(e);
  endtask

  task automatic check_outputs(input exp_t e);
    chk("gpi_data", gpi, e.gpi);
    chk("enable_tx", en_tx, e.tx);
    chk("enable_rx", en_rx, e.rx);
    chk("phase_sel", phase, e.phase);
  endtask

  task automatic run_cmd(input logic [7:0] op, input logic [22:0] pl);
    int   n, pulses;
    exp_t e;
    model_cmd(op, pl);
    @(posedge clock); #1;
    gpo = {op, 1'b1, pl};
    n = 0; pulses = 0;
    do begin
      @(negedge clock);
      n++;
      if (rst_sinc) pulses++;
    end while (!ack && n < 40);
    chk("ack_latency", n, (op == 8'h01) ? 3 + RESET_CYCLES : 3);
    chk("reset_pulse_len", pulses, (op == 8'h01) ? RESET_CYCLES : 0);
    chk("sb_depth", sb_q.size(), 1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_outputs(e);
    end
    @(posedge clock); #1;
    gpo[23] = 1'b0;
    @(negedge clock);
    chk("ack_hold", ack, 1);
    @(negedge clock);
    chk("ack_drop", ack, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   n, pulses, acks;
    rst_n = 1'b0; gpo = '0; bits = '0; errs = '0; led = 1'b0;
    model_reset();
    repeat (3) @(negedge clock);
    chk("rst_gpi", gpi, 0);
    chk("rst_ack", ack, 0);
    chk("rst_sinc", rst_sinc, 0);
    chk("rst_tx", en_tx, 0);
    chk("rst_rx", en_rx, 0);
    chk("rst_phase", phase, 0);
    @(posedge clock); #1 rst_n = 1'b1;

    run_cmd(8'h02, 23'h1);
    run_cmd(8'h01, 23'h0);

    bits = 64'h0000_0001_0000_0005;
    errs = 64'h0000_0000_0000_0002;
    run_cmd(8'h05, 23'h0);
    bits = 64'hDEAD_BEEF_1234_5678;
    errs = 64'hCAFE_F00D_8765_4321;
    run_cmd(8'h08, 23'h0);
    run_cmd(8'h09, 23'h0);
    run_cmd(8'h06, 23'h0);
    run_cmd(8'h07, 23'h0);

    run_cmd(8'h3F, 23'h7FFFFF);
    run_cmd(8'h0A, 23'h0);
    run_cmd(8'h03, 23'h1);
    run_cmd(8'h0A, 23'h0);
    led = 1'b1;
    run_cmd(8'h0A, 23'h0);
    run_cmd(8'h04, 23'h3);
`ifndef BER_REG_TIMESTAMP_EN
    run_cmd(8'h0B, 23'h0);
    run_cmd(8'h0A, 23'h0);
`endif

    // strobe held high across two commands: only the first executes
    model_cmd(8'h02, 23'h0);
    @(posedge clock); #1 gpo = 32'h0280_0000;
    repeat (4) @(negedge clock);
    @(posedge clock); #1 gpo = 32'h0280_0001;
    repeat (6) @(negedge clock);
    chk("held_ack", ack, 1);
    e = sb_q.pop_front();
    check_outputs(e);
    @(posedge clock); #1 gpo[23] = 1'b0;
    repeat (2) @(negedge clock);
    chk("held_ack_drop", ack, 0);

    // strobe dropped mid reset pulse: pulse completes, single-cycle ack
    model_cmd(8'h01, 23'h0);
    @(posedge clock); #1 gpo = 32'h0180_0000;
    repeat (2) @(posedge clock);
    #1 gpo[23] = 1'b0;
    pulses = 0; acks = 0;
    repeat (12) begin
      @(negedge clock);
      if (rst_sinc) pulses++;
      if (ack) acks++;
    end
    chk("early_pulse_len", pulses, RESET_CYCLES);
    chk("early_ack_cycles", acks, 1);
    e = sb_q.pop_front();
    check_outputs(e);

    // async reset in the second cycle of the pulse
    @(posedge clock); #1 gpo = 32'h0180_0000;
    n = 0;
    do begin @(negedge clock); n++; end while (!rst_sinc && n < 20);
    chk("pulse_started", rst_sinc, 1);
    @(posedge clock); #2 rst_n = 1'b0;
    #1;
    chk("async_sinc", rst_sinc, 0);
    chk("async_ack", ack, 0);
    chk("async_tx", en_tx, 0);
    gpo = '0;
    model_reset();
    repeat (2) @(negedge clock);
    @(posedge clock); #1 rst_n = 1'b1;
    run_cmd(8'h02, 23'h1);
    run_cmd(8'h0A, 23'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
